conv_mac_3x3: RTL and testbench

CONV_MAC_3X3 -- requirements
Module: conv_mac_3x3

---
 rtl/conv_mac_3x3_if.sv | 27 ++
 rtl/conv_mac_3x3.sv | 118 +++++++++++
 tb/tb_conv_mac_3x3.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_3x3_if.sv
// Bundles the 3x3 convolution MAC signals: the start/result handshake and
// the two synchronous read ports to the coefficient ROM and pixel window.
interface conv_mac_3x3_if;
  logic               start;
  logic               coef_en;
  logic [3:0]         coef_addr;
  logic signed [8:0]  coef_in;
  logic               pix_en;
  logic [3:0]         pix_addr;
  logic [7:0]         pix_in;
  logic signed [20:0] result;
  logic [7:0]         pix_out;
  logic               valid;
  logic               busy;

  // Requester / memory side: issues start, returns ROM and window data.
  modport master (
    output start, coef_in, pix_in,
    input  coef_en, coef_addr, pix_en, pix_addr, result, pix_out, valid, busy
  );

  // Convolution engine side.
  modport slave (
    input  start, coef_in, pix_in,
    output coef_en, coef_addr, pix_en, pix_addr, result, pix_out, valid, busy
  );
endinterface

// File: rtl/conv_mac_3x3.sv
// 3x3 convolution multiply-accumulate engine. One start walks taps 0..8
// through the coefficient ROM and pixel window (both with one cycle read
// latency), accumulates signed coef * unsigned pixel, and publishes the
// 21-bit sum plus an optional ReLU/clamped 8-bit pixel with a valid pulse.
module conv_mac_3x3 #(
  parameter bit RELU_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  conv_mac_3x3_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q;
  logic [3:0]         tap_q;
  logic               en_q;
  logic               tapValid_q;
  logic signed [20:0] acc_q;
  logic signed [20:0] result_q;
  logic [7:0]         pixOut_q;
  logic               valid_q;
  logic               busy_q;

  logic signed [16:0] coefExt;
  logic signed [16:0] pixExt;
  logic signed [16:0] prod;
  logic signed [20:0] prodExt;
  logic signed [20:0] acc_d;
  logic [7:0]         pixOut_d;

  // Product of the tap returned last cycle, folded into the running sum only
  // when that tap was actually requested.
  always_comb begin
    coefExt = {{8{bus.coef_in[8]}}, bus.coef_in};
    pixExt  = {9'd0, bus.pix_in};
    prod    = coefExt * pixExt;
    prodExt = {{4{prod[16]}}, prod};
    acc_d   = acc_q;
    if (tapValid_q) begin
      acc_d = acc_q + prodExt;
    end
  end

  // Output pixel: ReLU with saturation at 255, or plain truncation.
  always_comb begin
    pixOut_d = acc_d[7:0];
    if (RELU_EN) begin
      if (acc_d[20]) begin
        pixOut_d = 8'd0;
      end else if (acc_d > 21'sd255) begin
        pixOut_d = 8'd255;
      end
    end
  end

  // Sequencer: IDLE -> RUN (taps 0..8) -> DRAIN (last product lands) -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tap_q      <= 4'd0;
      en_q       <= 1'b0;
      tapValid_q <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      pixOut_q   <= 8'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      tapValid_q <= en_q;
      acc_q      <= acc_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            en_q    <= 1'b1;
            tap_q   <= 4'd0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          if (tap_q == 4'd8) begin
            state_q <= DRAIN;
            en_q    <= 1'b0;
            tap_q   <= 4'd0;
          end else begin
            tap_q <= tap_q + 4'd1;
          end
        end
        DRAIN: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          result_q <= acc_d;
          pixOut_q <= pixOut_d;
          valid_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
          tap_q   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.coef_en   = en_q;
  assign bus.coef_addr = tap_q;
  assign bus.pix_en    = en_q;
  assign bus.pix_addr  = tap_q;
  assign bus.result    = result_q;
  assign bus.pix_out   = pixOut_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_conv_mac_3x3.sv
// Directed bench for conv_mac_3x3: a ReLU build and a truncating build run
// side by side on the same ROM/window model, checked against hand sums.
module tb_conv_mac_3x3;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  logic signed [8:0] coefRom [16];
  logic [7:0]        pixRam  [16];

  conv_mac_3x3_if bus1 ();
  conv_mac_3x3_if bus0 ();

  conv_mac_3x3 #(.RELU_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  conv_mac_3x3 #(.RELU_EN(1'b0)) dutNoRelu (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  assign bus0.start   = bus1.start;
  assign bus0.coef_in = bus1.coef_in;
  assign bus0.pix_in  = bus1.pix_in;

  // Clock generation.
  always #5 clk = ~clk;

  // Synchronous coefficient ROM and pixel window, one cycle read latency.
  always @(posedge clk) begin
    if (bus1.coef_en) bus1.coef_in <= coefRom[bus1.coef_addr];
    if (bus1.pix_en)  bus1.pix_in  <= pixRam[bus1.pix_addr];
  end

  task automatic setLaplace();
    for (int i = 0; i < 16; i++) coefRom[i] = 9'sd0;
    coefRom[1] = -9'sd1;
    coefRom[3] = -9'sd1;
    coefRom[5] = -9'sd1;
    coefRom[7] = -9'sd1;
    coefRom[4] = 9'sd4;
  endtask

  task automatic setCoefAll(input int c);
    for (int i = 0; i < 16; i++) coefRom[i] = 9'(c);
  endtask

  task automatic setWindow(input int center, input int n1, input int n3,
                           input int n5, input int n7, input int other);
    for (int i = 0; i < 16; i++) pixRam[i] = 8'(other);
    pixRam[4] = 8'(center);
    pixRam[1] = 8'(n1);
    pixRam[3] = 8'(n3);
    pixRam[5] = 8'(n5);
    pixRam[7] = 8'(n7);
  endtask

  // Launches one operation and observes 21 cycles; optionally re-pulses
  // start so that it is sampled at edge E<pulseAt>.
  task automatic doOp(input int pulseAt, output int lat, output int nValid,
                      output int nAddr, output bit seqOk,
                      output logic signed [20:0] resMid, output bit busyMid);
    lat = -1; nValid = 0; nAddr = 0; seqOk = 1'b1; resMid = '0; busyMid = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    for (int m = 0; m <= 20; m++) begin
      @(negedge clk);
      if (bus1.coef_en === 1'b1) begin
        if (bus1.coef_addr !== 4'(nAddr) || bus1.pix_en !== 1'b1 ||
            bus1.pix_addr !== bus1.coef_addr) seqOk = 1'b0;
        nAddr++;
      end else if (bus1.pix_en !== 1'b0 || bus1.coef_addr !== 4'd0 ||
                   bus1.pix_addr !== 4'd0) begin
        seqOk = 1'b0;
      end
      if (bus1.valid === 1'b1) begin
        nValid++;
        if (lat < 0) lat = m;
      end
      if (m == 5) begin
        resMid  = bus1.result;
        busyMid = bus1.busy;
      end
      bus1.start = (m == pulseAt - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    compared++; if (bus1.result !== 21'sd0) begin mismatched++; $display("[TB] FAIL reset_result: got %0d want 0", bus1.result); end
    compared++; if (bus1.pix_out !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_pix_out: got %0d want 0", bus1.pix_out); end
    compared++; if (bus1.valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", bus1.valid); end
    compared++; if (bus1.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", bus1.busy); end
    compared++; if ({bus1.coef_en, bus1.pix_en, bus1.coef_addr, bus1.pix_addr} !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_mem_if: got en=%b/%b addr=%0d/%0d want all 0", bus1.coef_en, bus1.pix_en, bus1.coef_addr, bus1.pix_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (bus1.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_after_reset_busy: got %b want 0", bus1.busy); end
  endtask

  task automatic test_flat();
    int lat; int nValid; int nAddr; bit seqOk; logic signed [20:0] resMid; bit busyMid;
    setLaplace();
    setWindow(100, 100, 100, 100, 100, 100);
    doOp(0, lat, nValid, nAddr, seqOk, resMid, busyMid);
    compared++; if (lat !== 10) begin mismatched++; $display("[TB] FAIL flat_latency: got %0d want 10", lat); end
    compared++; if (nValid !== 1) begin mismatched++; $display("[TB] FAIL flat_valid_count: got %0d want 1", nValid); end
    compared++; if (nAddr !== 9 || !seqOk) begin mismatched++; $display("[TB] FAIL flat_addr_trace: got %0d taps ok=%0d want 9 ok=1", nAddr, seqOk); end
    compared++; if (busyMid !== 1'b1) begin mismatched++; $display("[TB] FAIL flat_busy_run: got %b want 1", busyMid); end
    compared++; if (bus1.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flat_busy_done: got %b want 0", bus1.busy); end
    compared++; if (bus1.result !== 21'sd0) begin mismatched++; $display("[TB] FAIL flat_result: got %0d want 0", bus1.result); end
    compared++; if (bus1.pix_out !== 8'd0) begin mismatched++; $display("[TB] FAIL flat_pix_out: got %0d want 0", bus1.pix_out); end
  endtask

  task automatic test_clamp_high();
    int lat; int nValid; int nAddr; bit seqOk; logic signed [20:0] resMid; bit busyMid;
    setLaplace();
    setWindow(200, 100, 100, 100, 100, 100);
    doOp(0, lat, nValid, nAddr, seqOk, resMid, busyMid);
    compared++; if (resMid !== 21'sd0) begin mismatched++; $display("[TB] FAIL clamp_result_held: got %0d want 0", resMid); end
    compared++; if (bus1.result !== 21'sd400) begin mismatched++; $display("[TB] FAIL clamp_result: got %0d want 400", bus1.result); end
    compared++; if (bus1.pix_out !== 8'd255) begin mismatched++; $display("[TB] FAIL clamp_pix_out: got %0d want 255", bus1.pix_out); end
    compared++; if (bus0.pix_out !== 8'h90) begin mismatched++; $display("[TB] FAIL clamp_pix_out_norelu: got %h want 90", bus0.pix_out); end
  endtask

  task automatic test_negative();
    int lat; int nValid; int nAddr; bit seqOk; logic signed [20:0] resMid; bit busyMid;
    setLaplace();
    setWindow(0, 50, 50, 50, 50, 0);
    doOp(0, lat, nValid, nAddr, seqOk, resMid, busyMid);
    compared++; if (resMid !== 21'sd400) begin mismatched++; $display("[TB] FAIL neg_result_held: got %0d want 400", resMid); end
    compared++; if (bus1.result !== -21'sd200) begin mismatched++; $display("[TB] FAIL neg_result: got %0d want -200", bus1.result); end
    compared++; if (bus1.pix_out !== 8'd0) begin mismatched++; $display("[TB] FAIL neg_pix_out: got %0d want 0", bus1.pix_out); end
    compared++; if (bus0.pix_out !== 8'h38) begin mismatched++; $display("[TB] FAIL neg_pix_out_norelu: got %h want 38", bus0.pix_out); end
  endtask

  task automatic test_max_positive();
    int lat; int nValid; int nAddr; bit seqOk; logic signed [20:0] resMid; bit busyMid;
    setCoefAll(255);
    setWindow(255, 255, 255, 255, 255, 255);
    doOp(0, lat, nValid, nAddr, seqOk, resMid, busyMid);
    compared++; if (bus1.result !== 21'sd585225) begin mismatched++; $display("[TB] FAIL max_result: got %0d want 585225", bus1.result); end
    compared++; if (bus1.pix_out !== 8'd255) begin mismatched++; $display("[TB] FAIL max_pix_out: got %0d want 255", bus1.pix_out); end
    compared++; if (bus0.pix_out !== 8'h09) begin mismatched++; $display("[TB] FAIL max_pix_out_norelu: got %h want 09", bus0.pix_out); end
  endtask

  task automatic test_start_while_busy();
    int lat; int nValid; int nAddr; bit seqOk; logic signed [20:0] resMid; bit busyMid;
    setLaplace();
    setWindow(0, 50, 50, 50, 50, 0);
    doOp(3, lat, nValid, nAddr, seqOk, resMid, busyMid);
    compared++; if (nValid !== 1) begin mismatched++; $display("[TB] FAIL busy_start_valid_count: got %0d want 1", nValid); end
    compared++; if (lat !== 10) begin mismatched++; $display("[TB] FAIL busy_start_latency: got %0d want 10", lat); end
    compared++; if (nAddr !== 9 || !seqOk) begin mismatched++; $display("[TB] FAIL busy_start_addr_trace: got %0d taps ok=%0d want 9 ok=1", nAddr, seqOk); end
    compared++; if (resMid !== 21'sd585225) begin mismatched++; $display("[TB] FAIL busy_start_result_held: got %0d want 585225", resMid); end
    compared++; if (bus1.result !== -21'sd200) begin mismatched++; $display("[TB] FAIL busy_start_result: got %0d want -200", bus1.result); end
  endtask

  task automatic test_reset_midrun();
    int lat; int nValid; int nAddr; bit seqOk; logic signed [20:0] resMid; bit busyMid;
    int seenValid;
    int seenBusy;
    setLaplace();
    setWindow(200, 100, 100, 100, 100, 100);
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (4) @(posedge clk);
    repeat (1) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    compared++; if (bus1.result !== 21'sd0) begin mismatched++; $display("[TB] FAIL abort_result: got %0d want 0", bus1.result); end
    compared++; if (bus0.pix_out !== 8'd0) begin mismatched++; $display("[TB] FAIL abort_pix_out_norelu: got %h want 00", bus0.pix_out); end
    compared++; if (bus1.busy !== 1'b0 || bus1.valid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy_valid: got %b/%b want 0/0", bus1.busy, bus1.valid); end
    compared++; if (bus1.coef_en !== 1'b0 || bus1.coef_addr !== 4'd0) begin mismatched++; $display("[TB] FAIL abort_mem_if: got en=%b addr=%0d want 0/0", bus1.coef_en, bus1.coef_addr); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seenValid = 0;
    seenBusy = 0;
    for (int m = 0; m < 15; m++) begin
      @(negedge clk);
      if (bus1.valid !== 1'b0) seenValid++;
      if (bus1.busy !== 1'b0) seenBusy++;
    end
    compared++; if (seenValid !== 0 || seenBusy !== 0) begin mismatched++; $display("[TB] FAIL abort_quiet: got valid=%0d busy=%0d cycles want 0/0", seenValid, seenBusy); end
    doOp(0, lat, nValid, nAddr, seqOk, resMid, busyMid);
    compared++; if (lat !== 10) begin mismatched++; $display("[TB] FAIL restart_latency: got %0d want 10", lat); end
    compared++; if (bus1.result !== 21'sd400) begin mismatched++; $display("[TB] FAIL restart_result: got %0d want 400", bus1.result); end
  endtask

  task automatic test_back_to_back();
    int expRes [3];
    int expPix [3];
    int expRaw [3];
    int validAt [3];
    int op;
    expRes = '{400, -40, 100};
    expPix = '{255, 0, 100};
    expRaw = '{8'h90, 8'hD8, 8'h64};
    validAt = '{-1, -1, -1};
    op = 0;
    setLaplace();
    setWindow(120, 20, 20, 20, 20, 20);
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    for (int m = 0; m < 40 && op < 3; m++) begin
      @(negedge clk);
      if (bus1.valid === 1'b1) begin
        validAt[op] = m;
        compared++; if (bus1.result !== 21'(expRes[op])) begin mismatched++; $display("[TB] FAIL b2b_result_%0d: got %0d want %0d", op, bus1.result, expRes[op]); end
        compared++; if (bus1.pix_out !== 8'(expPix[op]) || bus0.pix_out !== 8'(expRaw[op])) begin mismatched++; $display("[TB] FAIL b2b_pix_out_%0d: got %0d/%h want %0d/%h", op, bus1.pix_out, bus0.pix_out, expPix[op], expRaw[op]); end
        if (op == 0) setWindow(50, 60, 60, 60, 60, 60);
        if (op == 1) setWindow(90, 80, 70, 60, 50, 200);
        if (op == 2) bus1.start = 1'b0;
        op++;
      end
      if (m == 16) begin
        compared++; if (bus1.result !== 21'sd400) begin mismatched++; $display("[TB] FAIL b2b_result_held: got %0d want 400", bus1.result); end
      end
    end
    bus1.start = 1'b0;
    compared++; if (validAt[0] !== 10 || validAt[1] !== 21 || validAt[2] !== 32) begin mismatched++; $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d want 10,21,32", validAt[0], validAt[1], validAt[2]); end
    repeat (3) @(negedge clk);
    compared++; if (bus1.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_stop: got busy %b want 0", bus1.busy); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus1.start = 1'b0;
    setLaplace();
    setWindow(0, 0, 0, 0, 0, 0);
    test_reset();
    test_flat();
    test_clamp_high();
    test_negative();
    test_max_positive();
    test_start_while_busy();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
